// File: rtl/aes_core_arbiter.sv
// aes_core_arbiter: shares one AES core between the AXI-Lite register path
// and the AXIS stream path. Requests are arbitrated round-robin on a tie. The
// winner's block and key size are latched for the core. The core is started
// with a one-cycle pulse, and its result is routed back to the winner only. A
// watchdog aborts an operation that never completes; the abort loads a zero
// result and sets a sticky error flag.
//
// Ports
//   S_AXI_clk, S_AXI_aresetn      : clock, asynchronous active-low reset
//   reg_req/mode256/block         : register path request, key size, input block
//   reg_grant/done/result         : register path accept pulse, done pulse, held result
//   strm_req/mode256/block        : stream path request, key size, input block
//   strm_grant/done/result        : stream path accept pulse, done pulse, held result
//   core_start/mode256/block      : start pulse and latched operands to the core
//   core_done/result              : completion pulse and result from the core
//   busy                          : high whenever the arbiter is not idle
//   owner                         : current or last owner (0 = register, 1 = stream)
//   err_timeout, err_clear        : sticky watchdog abort flag and its clear

module aes_core_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic         S_AXI_clk,
    input  logic         S_AXI_aresetn,

    input  logic         reg_req,
    input  logic         reg_mode256,
    input  logic [127:0] reg_block,
    output logic         reg_grant,
    output logic         reg_done,
    output logic [127:0] reg_result,

    input  logic         strm_req,
    input  logic         strm_mode256,
    input  logic [127:0] strm_block,
    output logic         strm_grant,
    output logic         strm_done,
    output logic [127:0] strm_result,

    output logic         core_start,
    output logic         core_mode256,
    output logic [127:0] core_block,
    input  logic         core_done,
    input  logic [127:0] core_result,

    output logic         busy,
    output logic         owner,
    output logic         err_timeout,
    input  logic         err_clear
);

    localparam int unsigned BLK_W = 128;
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               owner_q, owner_d;
    logic               last_owner_q, last_owner_d;
    logic [CNT_W-1:0]   wd_cnt_q, wd_cnt_d;
    logic               err_q, err_d;
    logic               core_mode_q, core_mode_d;
    logic [BLK_W-1:0]   core_block_q, core_block_d;
    logic [BLK_W-1:0]   reg_result_q, reg_result_d;
    logic [BLK_W-1:0]   strm_result_q, strm_result_d;
    logic               reg_grant_q, reg_grant_d;
    logic               strm_grant_q, strm_grant_d;
    logic               core_start_q, core_start_d;
    logic               reg_done_q, reg_done_d;
    logic               strm_done_q, strm_done_d;
    logic               busy_q, busy_d;
    logic               win;

    // Next-state and next-output logic; all outputs are registered from *_d.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_owner_d  = last_owner_q;
        wd_cnt_d      = wd_cnt_q;
        err_d         = err_q;
        core_mode_d   = core_mode_q;
        core_block_d  = core_block_q;
        reg_result_d  = reg_result_q;
        strm_result_d = strm_result_q;
        reg_grant_d   = 1'b0;
        strm_grant_d  = 1'b0;
        core_start_d  = 1'b0;
        reg_done_d    = 1'b0;
        strm_done_d   = 1'b0;
        win           = 1'b0;

        // Clear first so that a watchdog abort in the same cycle overrides it.
        if (err_clear) begin
            err_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (reg_req || strm_req) begin
                    // On a tie the path not served last wins.
                    win          = (reg_req && strm_req) ? ~last_owner_q : strm_req;
                    owner_d      = win;
                    core_block_d = win ? strm_block   : reg_block;
                    core_mode_d  = win ? strm_mode256 : reg_mode256;
                    reg_grant_d  = ~win;
                    strm_grant_d = win;
                    core_start_d = 1'b1;
                    state_d      = S_START;
                end
            end

            S_START: begin
                wd_cnt_d = '0;
                state_d  = S_WAIT;
            end

            S_WAIT: begin
                // A completion on the watchdog's last cycle still counts as success.
                if (core_done) begin
                    if (owner_q) begin
                        strm_result_d = core_result;
                    end else begin
                        reg_result_d  = core_result;
                    end
                    reg_done_d  = ~owner_q;
                    strm_done_d = owner_q;
                    state_d     = S_DONE;
                end else if (wd_cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                    err_d = 1'b1;
                    if (owner_q) begin
                        strm_result_d = '0;
                    end else begin
                        reg_result_d  = '0;
                    end
                    reg_done_d  = ~owner_q;
                    strm_done_d = owner_q;
                    state_d     = S_DONE;
                end else begin
                    wd_cnt_d = wd_cnt_q + CNT_W'(1);
                end
            end

            S_DONE: begin
                last_owner_d = owner_q;
                state_d      = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge S_AXI_clk or negedge S_AXI_aresetn) begin
        if (!S_AXI_aresetn) begin
            state_q       <= S_IDLE;
            owner_q       <= 1'b0;
            last_owner_q  <= 1'b1;
            wd_cnt_q      <= '0;
            err_q         <= 1'b0;
            core_mode_q   <= 1'b0;
            core_block_q  <= '0;
            reg_result_q  <= '0;
            strm_result_q <= '0;
            reg_grant_q   <= 1'b0;
            strm_grant_q  <= 1'b0;
            core_start_q  <= 1'b0;
            reg_done_q    <= 1'b0;
            strm_done_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            last_owner_q  <= last_owner_d;
            wd_cnt_q      <= wd_cnt_d;
            err_q         <= err_d;
            core_mode_q   <= core_mode_d;
            core_block_q  <= core_block_d;
            reg_result_q  <= reg_result_d;
            strm_result_q <= strm_result_d;
            reg_grant_q   <= reg_grant_d;
            strm_grant_q  <= strm_grant_d;
            core_start_q  <= core_start_d;
            reg_done_q    <= reg_done_d;
            strm_done_q   <= strm_done_d;
            busy_q        <= busy_d;
        end
    end

    assign reg_grant    = reg_grant_q;
    assign reg_done     = reg_done_q;
    assign reg_result   = reg_result_q;
    assign strm_grant   = strm_grant_q;
    assign strm_done    = strm_done_q;
    assign strm_result  = strm_result_q;
    assign core_start   = core_start_q;
    assign core_mode256 = core_mode_q;
    assign core_block   = core_block_q;
    assign busy         = busy_q;
    assign owner        = owner_q;
    assign err_timeout  = err_q;

endmodule

// File: tb/tb_aes_core_arbiter.sv
// tb_aes_core_arbiter: directed bench for aes_core_arbiter with a small core
// model that returns ~block a fixed number of cycles after it sees core_start.
module tb_aes_core_arbiter;

    logic         clk;
    logic         rst_n;
    logic         reg_req, reg_mode256;
    logic [127:0] reg_block;
    logic         reg_grant, reg_done;
    logic [127:0] reg_result;
    logic         strm_req, strm_mode256;
    logic [127:0] strm_block;
    logic         strm_grant, strm_done;
    logic [127:0] strm_result;
    logic         core_start, core_mode256;
    logic [127:0] core_block;
    logic         core_done;
    logic [127:0] core_result;
    logic         busy, owner, err_timeout, err_clear;

    // Core model state: core_lat = 0 means the core never answers.
    int           core_lat;
    int           cnt;
    logic [127:0] blk;
    logic         model_done;
    logic [127:0] model_result;
    logic         man_done;
    logic [127:0] man_result;

    int checks;
    int errors;

    localparam logic [127:0] B1  = 128'h00111111_22222222_33333333_44444444;
    localparam logic [127:0] NB1 = 128'hFFEEEEEE_DDDDDDDD_CCCCCCCC_BBBBBBBB;
    localparam logic [127:0] BR  = 128'h01234567_89ABCDEF_00112233_44556677;
    localparam logic [127:0] NBR = 128'hFEDCBA98_76543210_FFEEDDCC_BBAA9988;
    localparam logic [127:0] BS  = 128'hDEADBEEF_CAFEF00D_12345678_9ABCDEF0;
    localparam logic [127:0] NBS = 128'h21524110_35010FF2_EDCBA987_6543210F;
    localparam logic [127:0] B3  = 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A5;
    localparam logic [127:0] NB3 = 128'h5A5A5A5A_5A5A5A5A_5A5A5A5A_5A5A5A5A;
    localparam logic [127:0] B4  = 128'h0F0F0F0F_00000000_FFFFFFFF_12121212;
    localparam logic [127:0] B5  = 128'h00000000_00000000_00000000_00000001;
    localparam logic [127:0] NB5 = 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE;
    localparam logic [127:0] B6  = 128'h13579BDF_2468ACE0_13579BDF_2468ACE0;
    localparam logic [127:0] B7  = 128'hFFFF0000_FFFF0000_FFFF0000_FFFF0000;
    localparam logic [127:0] NB7 = 128'h0000FFFF_0000FFFF_0000FFFF_0000FFFF;

    aes_core_arbiter #(.TIMEOUT_CYC(64)) dut (
        .S_AXI_clk     (clk),
        .S_AXI_aresetn (rst_n),
        .reg_req       (reg_req),
        .reg_mode256   (reg_mode256),
        .reg_block     (reg_block),
        .reg_grant     (reg_grant),
        .reg_done      (reg_done),
        .reg_result    (reg_result),
        .strm_req      (strm_req),
        .strm_mode256  (strm_mode256),
        .strm_block    (strm_block),
        .strm_grant    (strm_grant),
        .strm_done     (strm_done),
        .strm_result   (strm_result),
        .core_start    (core_start),
        .core_mode256  (core_mode256),
        .core_block    (core_block),
        .core_done     (core_done),
        .core_result   (core_result),
        .busy          (busy),
        .owner         (owner),
        .err_timeout   (err_timeout),
        .err_clear     (err_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign core_done   = model_done | man_done;
    assign core_result = man_done ? man_result : model_result;

    // Core model, advanced on the falling edge so its outputs are stable at
    // the rising edge; with core_lat = 11 the done pulse is sampled 11 edges
    // after the start pulse is first seen.
    always @(negedge clk) begin
        if (cnt != 0) begin
            cnt <= cnt - 1;
            if (cnt == 1) begin
                model_done   <= 1'b1;
                model_result <= ~blk;
            end else begin
                model_done   <= 1'b0;
            end
        end else begin
            model_done <= 1'b0;
        end
        if (core_start && core_lat != 0) begin
            cnt <= core_lat;
            blk <= core_block;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a grant, then for a done pulse, checking the path,
    // owner, key size and both result registers. Returns on the done cycle.
    task automatic run_txn(input logic exp_owner, input logic exp_mode,
                           input logic [127:0] exp_reg, input logic [127:0] exp_strm);
        int n;
        n = 0;
        while (!(reg_grant || strm_grant) && n < 10) begin
            tick(1);
            n++;
        end
        chk1("grant_seen", reg_grant | strm_grant, 1'b1);
        chk1("grant_reg", reg_grant, ~exp_owner);
        chk1("grant_strm", strm_grant, exp_owner);
        chk1("owner", owner, exp_owner);
        chk1("start_with_grant", core_start, 1'b1);
        chk1("core_mode", core_mode256, exp_mode);
        n = 0;
        while (!(reg_done || strm_done) && n < 40) begin
            tick(1);
            n++;
        end
        chk1("done_seen", reg_done | strm_done, 1'b1);
        chk1("done_reg", reg_done, ~exp_owner);
        chk1("done_strm", strm_done, exp_owner);
        chk128("reg_result", reg_result, exp_reg);
        chk128("strm_result", strm_result, exp_strm);
    endtask

    initial begin
        int bad;
        checks = 0; errors = 0;
        rst_n = 1'b0; err_clear = 1'b0;
        reg_req = 1'b0; reg_mode256 = 1'b0; reg_block = '0;
        strm_req = 1'b0; strm_mode256 = 1'b0; strm_block = '0;
        man_done = 1'b0; man_result = '0;
        core_lat = 11; cnt = 0; blk = '0; model_done = 1'b0; model_result = '0;

        // Reset state
        tick(2);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_owner", owner, 1'b0);
        chk1("rst_err", err_timeout, 1'b0);
        chk1("rst_start", core_start, 1'b0);
        chk1("rst_rgrant", reg_grant, 1'b0);
        chk128("rst_cblock", core_block, '0);
        chk128("rst_rres", reg_result, '0);
        chk128("rst_sres", strm_result, '0);
        rst_n = 1'b1;
        tick(3);
        chk1("idle_no_start", core_start, 1'b0);
        chk1("idle_busy", busy, 1'b0);

        // Single register request, exact latency
        reg_block = B1; reg_mode256 = 1'b0; reg_req = 1'b1;
        tick(1);
        chk1("a_rgrant", reg_grant, 1'b1);
        chk1("a_sgrant", strm_grant, 1'b0);
        chk1("a_start", core_start, 1'b1);
        chk1("a_mode", core_mode256, 1'b0);
        chk128("a_cblock", core_block, B1);
        chk1("a_owner", owner, 1'b0);
        chk1("a_busy", busy, 1'b1);
        reg_req = 1'b0;
        bad = 0;
        for (int c = 2; c <= 12; c++) begin
            tick(1);
            if (reg_done || strm_done || core_start || reg_grant) bad++;
        end
        chk_int("a_no_early_done", bad, 0);
        tick(1);
        chk1("a_rdone_c13", reg_done, 1'b1);
        chk1("a_sdone", strm_done, 1'b0);
        chk128("a_rres", reg_result, NB1);
        chk128("a_sres", strm_result, '0);
        tick(1);
        chk1("a_rdone_1cyc", reg_done, 1'b0);
        chk1("a_idle", busy, 1'b0);
        chk128("a_rres_held", reg_result, NB1);

        // Both requests from reset: reg, strm, reg, strm
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        reg_block = BR; reg_mode256 = 1'b0;
        strm_block = BS; strm_mode256 = 1'b1;
        reg_req = 1'b1; strm_req = 1'b1;
        run_txn(1'b0, 1'b0, NBR, '0);
        run_txn(1'b1, 1'b1, NBR, NBS);
        run_txn(1'b0, 1'b0, NBR, NBS);
        run_txn(1'b1, 1'b1, NBR, NBS);
        reg_req = 1'b0; strm_req = 1'b0;
        tick(2);

        // core_done during IDLE is ignored
        man_result = 128'h12345678_12345678_12345678_12345678;
        man_done = 1'b1;
        tick(1);
        man_done = 1'b0;
        chk1("i_rdone", reg_done, 1'b0);
        chk1("i_sdone", strm_done, 1'b0);
        chk1("i_busy", busy, 1'b0);
        tick(1);
        chk1("i_rdone2", reg_done | strm_done, 1'b0);
        chk128("i_rres", reg_result, NBR);
        chk128("i_sres", strm_result, NBS);

        // core_done during START is ignored; the real completion follows
        reg_block = B3; reg_req = 1'b1;
        tick(1);
        chk1("s_rgrant", reg_grant, 1'b1);
        man_done = 1'b1; reg_req = 1'b0;
        tick(1);
        man_done = 1'b0;
        chk1("s_rdone", reg_done, 1'b0);
        chk1("s_busy", busy, 1'b1);
        tick(11);
        chk1("s_rdone_c13", reg_done, 1'b1);
        chk128("s_rres", reg_result, NB3);
        chk128("s_sres", strm_result, NBS);
        tick(1);

        // Watchdog abort on the stream path
        core_lat = 0;
        tick(1);
        strm_block = B4; strm_mode256 = 1'b0; strm_req = 1'b1;
        tick(1);
        chk1("t_sgrant", strm_grant, 1'b1);
        chk1("t_owner", owner, 1'b1);
        strm_req = 1'b0;
        bad = 0;
        for (int c = 2; c <= 65; c++) begin
            tick(1);
            if (strm_done || reg_done || err_timeout) bad++;
        end
        chk_int("t_no_early_done", bad, 0);
        tick(1);
        chk1("t_sdone_c66", strm_done, 1'b1);
        chk1("t_err", err_timeout, 1'b1);
        chk128("t_sres_zero", strm_result, '0);
        chk128("t_rres_kept", reg_result, NB3);
        tick(1);
        chk1("t_err_sticky", err_timeout, 1'b1);
        chk1("t_idle", busy, 1'b0);
        err_clear = 1'b1;
        tick(1);
        err_clear = 1'b0;
        chk1("t_err_cleared", err_timeout, 1'b0);

        // core_done on the last watchdog cycle wins
        core_lat = 64;
        tick(1);
        reg_block = B5; reg_mode256 = 1'b1; reg_req = 1'b1;
        tick(1);
        chk1("w_rgrant", reg_grant, 1'b1);
        reg_req = 1'b0;
        tick(64);
        chk1("w_rdone_c65", reg_done, 1'b0);
        tick(1);
        chk1("w_rdone_c66", reg_done, 1'b1);
        chk128("w_rres", reg_result, NB5);
        chk1("w_err", err_timeout, 1'b0);
        tick(1);

        // Reset 5 cycles into WAIT, late core_done ignored afterwards
        core_lat = 11;
        tick(1);
        strm_block = B6; strm_mode256 = 1'b1; strm_req = 1'b1;
        tick(1);
        chk1("r_sgrant", strm_grant, 1'b1);
        chk1("r_mode", core_mode256, 1'b1);
        strm_req = 1'b0;
        tick(5);
        chk1("r_busy_wait", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk1("r_busy", busy, 1'b0);
        chk1("r_owner", owner, 1'b0);
        chk1("r_err", err_timeout, 1'b0);
        chk1("r_start", core_start, 1'b0);
        chk1("r_grants", reg_grant | strm_grant, 1'b0);
        chk1("r_dones", reg_done | strm_done, 1'b0);
        chk1("r_cmode", core_mode256, 1'b0);
        chk128("r_cblock", core_block, '0);
        chk128("r_rres", reg_result, '0);
        chk128("r_sres", strm_result, '0);
        tick(1);
        rst_n = 1'b1;
        bad = 0;
        for (int c = 8; c <= 14; c++) begin
            tick(1);
            if (core_start || busy || reg_done || strm_done || err_timeout) bad++;
            if (strm_result != '0 || reg_result != '0) bad++;
        end
        chk_int("r_late_done_ignored", bad, 0);
        reg_block = B7; reg_mode256 = 1'b0; reg_req = 1'b1;
        run_txn(1'b0, 1'b0, NB7, '0);
        reg_req = 1'b0;
        tick(2);
        chk1("end_idle", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
